// File: rtl/simd_mult_unit.sv
// Packed-lane unsigned multiplier. Each lane runs one shift-add step per clock.
// A lane product is the low DATA_W bits of op_a lane times op_b lane, and it is ready after DATA_W steps.
module simd_mult_unit #(
    parameter int DATA_W = 16,
    parameter int LANES  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LANES*DATA_W-1:0] op_a,
    input  logic [LANES*DATA_W-1:0] op_b,
    input  logic [4:0]              waddr_in,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*DATA_W-1:0] result,
    output logic [4:0]              waddr_out,
    output logic                    reg_write_out
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_waddr;
    logic             w_accept;
    logic             w_last;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_waddr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt   <= '0;
                r_waddr <= waddr_in;
            end else if (r_state == RUN) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    assign busy          = (r_state == RUN);
    assign done          = (r_state == DONE);
    assign reg_write_out = (r_state == DONE);
    assign waddr_out     = r_waddr;

    // Lane 0 sits in the MSBs. Each lane keeps its own registered product, and that product changes only at the end of a run.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int LO = (LANES - 1 - gi) * DATA_W;

            logic [DATA_W-1:0] r_a;
            logic [DATA_W-1:0] r_b;
            logic [DATA_W-1:0] r_acc;
            logic [DATA_W-1:0] r_res;
            logic [DATA_W-1:0] w_addend;
            logic [DATA_W-1:0] w_sum;

            always_comb begin
                w_addend = r_b[r_cnt] ? (r_a << r_cnt) : '0;
                w_sum    = r_acc + w_addend;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_acc <= '0;
                    r_res <= '0;
                end else if (w_accept) begin
                    r_a   <= op_a[LO +: DATA_W];
                    r_b   <= op_b[LO +: DATA_W];
                    r_acc <= '0;
                end else if (r_state == RUN) begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_res <= w_sum;
                    end
                end
            end

            assign result[LO +: DATA_W] = r_res;
        end
    endgenerate

endmodule

// File: doc/simd_mult_unit.md
SIMD_MULT_UNIT -- requirements
Module: simd_mult_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of one lane.
REQ-002 SHALL have parameter LANES, default 5, number of packed lanes.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to multiply the current operands.
REQ-006 SHALL have port op_a, input, LANES*DATA_W bits: packed multiplicand lanes from register read port 1.
REQ-007 SHALL have port op_b, input, LANES*DATA_W bits: packed multiplier lanes from register read port 2.
REQ-008 SHALL have port waddr_in, input, 5 bits: destination register for the result.
REQ-009 SHALL have port busy, output, 1 bit: multiply in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-011 SHALL have port result, output, LANES*DATA_W bits: packed per-lane products to register write data.
REQ-012 SHALL have port waddr_out, output, 5 bits: latched destination register.
REQ-013 SHALL have port reg_write_out, output, 1 bit: write enable to register file, equal to done.

Function
REQ-014 SHALL pack lane 0 in the MSBs (bits LANES*DATA_W-1 down to (LANES-1)*DATA_W), lane LANES-1 in the LSBs, for op_a, op_b and result.
REQ-015 SHALL compute per lane the low DATA_W bits of the unsigned product op_a lane x op_b lane; overflow bits are discarded; no lane affects another.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL accept start only in IDLE or DONE; on acceptance it latches op_a, op_b, waddr_in, clears accumulators and the bit counter, and enters RUN.
REQ-018 SHALL ignore start while in RUN; latched operands remain unchanged.
REQ-019 SHALL, in RUN, process one multiplier bit per cycle per lane, LSB first: if bit i of the op_b lane is set, add (op_a lane << i) to the lane accumulator, truncated to DATA_W.
REQ-020 SHALL stay in RUN exactly DATA_W cycles, then enter DONE.
REQ-021 SHALL assert done and reg_write_out only in DONE, for exactly one cycle.
REQ-022 SHALL leave DONE for IDLE next cycle, or for RUN if start is high in DONE (back-to-back operation).
REQ-023 SHALL drive busy high only in RUN.
REQ-024 SHALL present result as the final accumulators from DONE onward and hold it, with waddr_out, until the next accepted start.
REQ-025 SHALL give latency: start sampled at edge 0 -> busy high in cycles 1..DATA_W -> done high in cycle DATA_W+1.
REQ-026 SHALL give zero operands no shortcut; latency is fixed regardless of data.

Reset
REQ-027 SHALL, when rst is high at a rising edge, enter IDLE with busy=0, done=0, reg_write_out=0, result=0, waddr_out=0, accumulators and counter 0.
REQ-028 SHALL abort an operation in progress when rst is asserted mid-RUN, with no done pulse, and ignore start while rst is high.
REQ-029 SHALL give rst priority over start in the same cycle.

Verification (DATA_W=16, LANES=5)
REQ-030 SHALL verify: start, lanes a={3,0x00FF,0xFFFF,0,1}, b={5,0x0101,0xFFFF,0x1234,0x1234}, waddr_in=7 -> busy cycles 1-16, done and reg_write_out high in cycle 17 only, result={15,0xFFFF,0x0001,0,0x1234}, waddr_out=7.
REQ-031 SHALL verify: start pulsed again at cycle 5 with different operands -> ignored; cycle-17 result unchanged from REQ-030.
REQ-032 SHALL verify: start held high through DONE with new operands a={2,2,2,2,2}, b={0x8000,...} -> RUN re-entered at cycle 18, second done in cycle 34, result all lanes 0x0000 (overflow discarded).
REQ-033 SHALL verify: rst asserted in cycle 8 of RUN -> next cycle busy=0, result=0, no done pulse ever; a following start completes normally with 17-cycle latency.
REQ-034 SHALL verify: rst and start both high in the same cycle -> remains IDLE, busy stays 0.
REQ-035 SHALL verify: random operands, 1000 operations -> every lane matches (a*b) mod 2^16 and done is always a single-cycle pulse.
